// File: rtl/fetch_unit.sv
// RV32I fetch front end: program counter, credit-limited in-order memory requests,
// instruction buffer with pre-split decode fields, and redirect flush.
// Build macro FETCH_PERF_EN adds the perf_fetched / perf_dropped counters.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct7_5
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   head_q, tail_q;
  logic [AW-1:0]   pf_rd_q, pf_wr_q;
  logic [CW:0]     credit_used;

  logic [XLEN-1:0] buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic [XLEN-1:0] pf_pc     [DEPTH];

  logic req_fire, pop, rsp_drop, push;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
  assign req_fire    = imem_req_valid && imem_req_ready;
  assign pop         = instr_valid && instr_ready;
  // A response in a redirect cycle belongs to the old stream, as does one owed to drop_q.
  assign rsp_drop    = imem_rsp_valid && (redirect_valid || (drop_q != '0));
  assign push        = imem_rsp_valid && !rsp_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    case (state_q)
      BOOT: state_d        = RUN;
      RUN:  imem_req_valid = credit_used < DEPTH_W;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (req_fire && !imem_rsp_valid)      inflight_d = inflight_q + CW'(1);
    else if (!req_fire && imem_rsp_valid) inflight_d = inflight_q - CW'(1);

    count_d = count_q;
    if (redirect_valid)     count_d = '0;
    else if (push && !pop)  count_d = count_q + CW'(1);
    else if (pop && !push)  count_d = count_q - CW'(1);

    // Everything still outstanding after this cycle, including a request accepted now, is stale.
    drop_d = drop_q;
    if (redirect_valid)                       drop_d = inflight_d;
    else if (imem_rsp_valid && drop_q != '0)  drop_d = drop_q - CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pf_rd_q    <= '0;
      pf_wr_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      drop_q     <= drop_d;

      if (redirect_valid) pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)  pc_q <= pc_q + XLEN'(4);

      // The PC FIFO tracks every accepted request, stale or not, so it is never flushed.
      if (req_fire)       pf_wr_q <= pf_wr_q + AW'(1);
      if (imem_rsp_valid) pf_rd_q <= pf_rd_q + AW'(1);

      if (redirect_valid) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + AW'(1);
        if (pop)  head_q <= head_q + AW'(1);
      end
    end
  end

  // NOTE: storage arrays have no reset; occupancy and pointers gate every read of them.
  always_ff @(posedge clk) begin
    if (req_fire) pf_pc[pf_wr_q] <= pc_q;
    if (push) begin
      buf_instr[tail_q] <= imem_rsp_data;
      buf_pc[tail_q]    <= pf_pc[pf_rd_q];
    end
  end

  assign imem_req_addr = pc_q;
  assign instr_valid   = count_q != '0;
  assign instr         = instr_valid ? buf_instr[head_q] : '0;
  assign instr_pc      = instr_valid ? buf_pc[head_q]    : '0;
  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7_5      = instr[30];

`ifdef FETCH_PERF_EN
  logic [31:0] drop_inc;

  always_comb begin
    drop_inc = 32'(rsp_drop);
    if (redirect_valid) drop_inc = drop_inc + 32'(count_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_dropped <= perf_dropped + drop_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency/ready, and a
// program-order reference (sequential PCs, reset to target on redirect).
module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc = 0;
  int    last_due = 0;
  int    lat_min = 1, lat_max = 1;
  bit    rdy_rand = 1'b0;
  int    irdy_mode = 0;
  bit    irdy_val = 1'b1;
  bit    irdy_alt = 1'b0;
  logic [31:0] exp_pc, exp_req_addr, redir_tgt_prev;
  bit    redir_prev = 1'b0;
  int    n_fire = 0, n_pop = 0;

  bit          s_iv, s_rspv, s_rv, s_pop;
  logic [31:0] s_pc;
  logic [6:0]  s_op;
  logic [2:0]  s_f3;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  task automatic do_reset();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    mq.delete();
    last_due     = 0;
    exp_pc       = RESET_PC;
    exp_req_addr = RESET_PC;
    redir_prev   = 1'b0;
    irdy_alt     = 1'b0;
    rdy_rand     = 1'b0;
    lat_min      = 1;
    lat_max      = 1;
    irdy_mode    = 0;
    irdy_val     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then let the rising edge happen.
  task automatic tick(input bit redir, input logic [31:0] tgt);
    logic [31:0] w;
    int          l;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    imem_req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    case (irdy_mode)
      0:       instr_ready = irdy_val;
      1:       begin irdy_alt = ~irdy_alt; instr_ready = irdy_alt; end
      default: instr_ready = 1'($urandom_range(1, 0));
    endcase
    redirect_valid = redir;
    redirect_pc    = tgt;
    #1;
    s_iv = instr_valid; s_pc = instr_pc; s_op = opcode; s_f3 = funct3;
    s_rspv = imem_rsp_valid; s_rv = imem_req_valid;
    s_pop = instr_valid && instr_ready && !redir;

    if (redir_prev) begin
      n_tests++;
      if (imem_req_addr !== redir_tgt_prev) begin
        n_fail++;
        $display("FAIL redirect_addr: got %h expected %h", imem_req_addr, redir_tgt_prev);
      end
      n_tests++;
      if (instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL redirect_flush: instr_valid got %b expected 0", instr_valid);
      end
    end

    if (imem_req_valid && imem_req_ready) begin
      n_fire++;
      n_tests++;
      if (imem_req_addr !== exp_req_addr) begin
        n_fail++;
        $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_req_addr);
      end
      l = int'($urandom_range(lat_max, lat_min));
      last_due = (last_due + 1 > cyc + l) ? last_due + 1 : cyc + l;
      mq.push_back(mreq_t'{imem_req_addr, last_due});
      exp_req_addr = exp_req_addr + 32'd4;
      n_tests++;
      if (mq.size() > DEPTH) begin
        n_fail++;
        $display("FAIL credit: outstanding got %0d expected <= %0d", mq.size(), DEPTH);
      end
    end

    if (instr_valid && instr_ready) begin
      n_pop++;
      if (!redir) begin
        w = mem_word(exp_pc);
        n_tests++;
        if (instr_pc !== exp_pc || instr !== w) begin
          n_fail++;
          $display("FAIL stream: got pc %h instr %h expected pc %h instr %h", instr_pc, instr, exp_pc, w);
        end
        n_tests++;
        if ({funct7_5, funct3, opcode} !== {w[30], w[14:12], w[6:0]}) begin
          n_fail++;
          $display("FAIL fields: got %b_%b_%b expected %b_%b_%b",
                   funct7_5, funct3, opcode, w[30], w[14:12], w[6:0]);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end

    if (redir) begin
      exp_pc       = {tgt[31:2], 2'b00};
      exp_req_addr = {tgt[31:2], 2'b00};
    end
    redir_prev     = redir;
    redir_tgt_prev = {tgt[31:2], 2'b00};
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_tests++;
    if ({imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, opcode, funct3, funct7_5} !==
        {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 7'h0, 3'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got req_valid %b addr %h instr_valid %b instr %h pc %h",
               imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc);
    end
    do_reset();
    #1;
    n_tests++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_idle: req_valid got %b expected 0", imem_req_valid);
    end
    tick(1'b0, '0);
    n_tests++;
    if (n_fire != 1 || s_rv !== 1'b1) begin
      n_fail++;
      $display("FAIL first_request: fires got %0d expected 1", n_fire);
    end
  endtask

  task automatic test_basic();
    bit seen = 1'b0, check_next = 1'b0;
    int p0;
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, '0);
      if (check_next) begin
        check_next = 1'b0;
        n_tests++;
        if ({s_iv, s_pc, s_op, s_f3} !== {1'b1, 32'h0, 7'h13, 3'h0}) begin
          n_fail++;
          $display("FAIL first_instr: got valid %b pc %h opcode %h funct3 %h expected 1 0 13 0",
                   s_iv, s_pc, s_op, s_f3);
        end
      end
      if (!seen && s_rspv) begin
        seen = 1'b1;
        check_next = 1'b1;
        n_tests++;
        if (s_iv !== 1'b0) begin
          n_fail++;
          $display("FAIL no_bypass: instr_valid got %b expected 0", s_iv);
        end
      end
    end
    n_tests++;
    if (!seen || n_pop - p0 < 10) begin
      n_fail++;
      $display("FAIL basic_progress: pops got %0d expected >= 10", n_pop - p0);
    end
  endtask

  task automatic test_back_pressure();
    int f0, p0;
    do_reset();
    irdy_val = 1'b0;
    f0 = n_fire;
    repeat (10) tick(1'b0, '0);
    n_tests++;
    if (n_fire - f0 != DEPTH || s_rv !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_requests: got %0d (req_valid %b) expected %0d (0)", n_fire - f0, s_rv, DEPTH);
    end
    for (int k = 0; k < 2; k++) begin
      f0 = n_fire;
      p0 = n_pop;
      irdy_val = 1'b1;
      tick(1'b0, '0);
      irdy_val = 1'b0;
      repeat (5) tick(1'b0, '0);
      n_tests++;
      if (n_pop - p0 != 1 || n_fire - f0 != 1) begin
        n_fail++;
        $display("FAIL request_per_pop: got pops %0d fires %0d expected 1 1", n_pop - p0, n_fire - f0);
      end
    end
  endtask

  task automatic test_redirect();
    bit ok = 1'b0, got = 1'b0;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1'b0, '0);
      ok = (mq.size() == 2);
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL redirect_setup: in-flight got %0d expected 2", mq.size());
    end
    tick(1'b1, 32'h103);
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1'b0, '0);
      if (s_pop) begin
        got = 1'b1;
        n_tests++;
        if (s_pc !== 32'h100) begin
          n_fail++;
          $display("FAIL redirect_first_pc: got %h expected 00000100", s_pc);
        end
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL redirect_resume: got no instruction expected pc 00000100");
    end
  endtask

  task automatic test_rsp_redirect();
    bit ok = 1'b0, got = 1'b0;
    do_reset();
    lat_max = 2;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mq.size() > 0 && mq[0].due <= cyc) ok = 1'b1;
      else tick(1'b0, '0);
    end
    tick(1'b1, 32'h200);
    n_tests++;
    if (!ok || s_rspv !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_redirect_setup: response got %b expected 1", s_rspv);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1'b0, '0);
      if (s_pop) begin
        got = 1'b1;
        n_tests++;
        if (s_pc !== 32'h200) begin
          n_fail++;
          $display("FAIL rsp_redirect_pc: got %h expected 00000200", s_pc);
        end
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL rsp_redirect_resume: got no instruction expected pc 00000200");
    end
  endtask

  task automatic test_wrap();
    int p0;
    do_reset();
    irdy_mode = 1;
    p0 = n_pop;
    for (int i = 0; i < 100 && (n_pop - p0) < 10; i++) tick(1'b0, '0);
    n_tests++;
    if (n_pop - p0 < 10) begin
      n_fail++;
      $display("FAIL wrap_progress: pops got %0d expected 10", n_pop - p0);
    end
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    rdy_rand  = 1'b1;
    lat_min   = 1;
    lat_max   = 4;
    irdy_mode = 2;
    p0 = n_pop;
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(24, 0) == 0, $urandom);
    n_tests++;
    if (n_pop - p0 < 50) begin
      n_fail++;
      $display("FAIL random_progress: pops got %0d expected >= 50", n_pop - p0);
    end
  endtask

  task automatic test_async_reset();
    int p0;
    do_reset();
    irdy_val = 1'b0;
    repeat (8) tick(1'b0, '0);
    n_tests++;
    if (s_iv !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: instr_valid got %b expected 1", s_iv);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, opcode, funct3, funct7_5} !==
        {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 7'h0, 3'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got req_valid %b addr %h instr_valid %b instr %h pc %h",
               imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc);
    end
    do_reset();
    p0 = n_pop;
    repeat (12) tick(1'b0, '0);
    n_tests++;
    if (n_pop - p0 < 3) begin
      n_fail++;
      $display("FAIL async_restart: pops got %0d expected >= 3", n_pop - p0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_redirect();
    test_rsp_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RV32I core: owns the program counter, issues in-order word requests to instruction memory, buffers returned instructions, and presents them with pre-split decode fields (opcode, funct3, funct7 bit 5) to the control/decode stage. It is the producing end of the decoder's instruction interface and the consuming end of its PC-select decision, delivered here as a redirect. Redirects flush buffered and in-flight fetches.

## Interface
- XLEN, 32, data and address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, instruction buffer entries; also the maximum number of outstanding memory requests (power of two, at least 2)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  returned instruction valid; in order, never back-pressured
- imem_rsp_data  in  XLEN  returned instruction word
- redirect_valid  in  1  taken branch/jump from the controller
- redirect_pc  in  XLEN  target address; bits [1:0] ignored
- instr_valid  out  1  buffered instruction available
- instr_ready  in  1  decode stage consumes the instruction
- instr  out  XLEN  instruction word
- instr_pc  out  XLEN  address of instr
- opcode  out  7  instr[6:0]
- funct3  out  3  instr[14:12]
- funct7_5  out  1  instr[30]

## Operation
- FSM states:
  - BOOT: entered on reset; no requests issued.
  - RUN: normal fetch. BOOT→RUN on the first clock edge after reset deasserts. No other transitions.
- PC register:
  - Advances by 4 on each accepted request (imem_req_valid && imem_req_ready).
  - On redirect_valid, loads {redirect_pc[XLEN-1:2], 2'b00}. Redirect has priority over increment.
- Credit rule:
  - imem_req_valid = (state==RUN) && (inflight + count < DEPTH).
  - inflight counts accepted requests without a response, including stale ones.
  - count is buffer occupancy.
- Responses:
  - Each returning response decrements inflight.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements. Otherwise it is pushed with its PC, taken from a parallel PC FIFO.
- Buffer: circular FIFO of DEPTH entries, holding {instr, pc}.
  - Outputs reflect the head entry.
  - Pop on instr_valid && instr_ready.
  - Pointers wrap modulo DEPTH.
- Redirect cycle:
  - Buffer is cleared: count←0, pointers reset.
  - drop_cnt←inflight, counted after this cycle's request acceptance and response.
  - A request accepted in the redirect cycle is stale; it used the old PC.
  - A response arriving in the redirect cycle is discarded.
  - A simultaneous pop is legal; the consumer must ignore it.
- Decode fields are pure slices of the head entry. They are 0 when the buffer is empty.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - instr_valid=0; instr, instr_pc, opcode, funct3, funct7_5 all 0.
  - PC=RESET_PC; inflight, count, drop_cnt = 0; state=BOOT.
- First request is asserted in the cycle after reset deasserts, with addr=RESET_PC.
- Response in cycle N: entry is visible on instr_valid in cycle N+1 (registered; no bypass).
- Buffer full with one pop and one push in the same cycle: both occur, occupancy unchanged.
- Redirect in cycle N: imem_req_addr=target in cycle N+1, and instr_valid=0 in cycle N+1.
- Reset asserted mid-operation: all state clears immediately. Responses still in flight when reset releases are not the block's concern; the memory must be reset together with this block.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched (32 bits, increments per instr handshake) and perf_dropped (32 bits, increments per discarded response plus per flushed buffer entry).
  - Both counters reset to 0 and wrap at 2^32.
- FETCH_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset release, memory always ready, 1-cycle latency, instr_ready=1:
  - Requests go to 0x0, 0x4, 0x8, and so on.
  - Memory returns 0x00500093 from 0x0 → instr_valid with opcode=7'h13, funct3=0, instr_pc=0x0, one cycle after the response.
- Back-pressure, instr_ready=0, DEPTH=2:
  - Exactly 2 requests are issued, then imem_req_valid=0.
  - Raise instr_ready → one new request per pop.
- Redirect to 0x103 with 2 requests in flight:
  - Next request address is 0x100.
  - Both stale responses are discarded; the first instr_pc seen is 0x100.
  - perf_dropped=2 with FETCH_PERF_EN.
- Simultaneous response and redirect in the same cycle:
  - The response is dropped and instr_valid=0 in the next cycle.
  - Then fetch resumes at the target.
- Buffer wrap: run 10 instructions through DEPTH=2 with alternating instr_ready → order and PCs are preserved and nothing is lost.
- Asynchronous reset asserted mid-stream:
  - Outputs go to reset values without waiting for a clock edge.
  - Fetch restarts at RESET_PC.
